// File: rtl/rect_drawer.sv
// Rectangle rasteriser: accepts one rectangle request and streams its pixels to the VGA adapter.
// Define RECT_DRAWER_CLIP_EN to suppress off-screen pixels; otherwise coordinates wrap.
module rect_drawer #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               s_ready,
  input  logic               s_valid,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic [X_W-1:0]     in_w,
  input  logic [Y_W-1:0]     in_h,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_outline,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  input  logic               vga_ready,
  output logic               done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef RECT_DRAWER_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  localparam logic [X_W:0]   SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  logic [1:0]         state_q, state_d;
  logic [X_W-1:0]     x_q, x_d, w_q, w_d, col_q, col_d;
  logic [Y_W-1:0]     y_q, y_d, h_q, h_d, row_q, row_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               outline_q, outline_d;

  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic         on_screen, visible, col_last, row_last, is_edge, emit, advance;

  // One extra bit so positions past the right/bottom edge never alias back on-screen.
  assign px        = {1'b0, x_q} + {1'b0, col_q};
  assign py        = {1'b0, y_q} + {1'b0, row_q};
  assign on_screen = (px < SCR_W) && (py < SCR_H);
  assign visible   = on_screen || !CLIP_EN;

  assign col_last = (col_q == w_q - X_ONE);
  assign row_last = (row_q == h_q - Y_ONE);
  assign is_edge  = (col_q == '0) || col_last || (row_q == '0) || row_last;

  // Hidden positions skip ahead every cycle; plotted ones wait for the adapter.
  assign emit    = (state_q == DRAW) && visible && (!outline_q || is_edge);
  assign advance = (state_q == DRAW) && (!emit || vga_ready);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    outline_d = outline_q;
    col_d     = col_q;
    row_d     = row_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          x_d       = in_x;
          y_d       = in_y;
          w_d       = in_w;
          h_d       = in_h;
          color_d   = in_color;
          outline_d = in_outline;
          col_d     = '0;
          row_d     = '0;
          state_d   = ((in_w == '0) || (in_h == '0)) ? DONE : DRAW;
        end
      end
      DRAW: begin
        if (advance) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + Y_ONE;
          end else begin
            col_d = col_q + X_ONE;
          end
          if (col_last && row_last) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      outline_q <= outline_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign plot    = emit;
  assign vga_x   = px[X_W-1:0];
  assign vga_y   = py[Y_W-1:0];
  assign colour  = color_q;

endmodule

// File: doc/rect_drawer.md
Name: rect_drawer

Overview:
Parametrised rectangle rasteriser for the Pong screen pipeline. It accepts one rectangle request (position, size, colour, fill/outline mode) over a ready/valid handshake. It then emits one pixel per cycle to the VGA adapter, honouring backpressure from the adapter and clipping pixels that fall off-screen. It is the generalised successor of the fixed 160x120 box drawer, sitting between the screen-drawer processor and the VGA adapter.

Parameters:
X_W, 9, width of x coordinate and rectangle width fields
Y_W, 8, width of y coordinate and rectangle height fields
COLOR_W, 3, colour width
SCREEN_W, 160, visible screen width in pixels (clip bound)
SCREEN_H, 120, visible screen height in pixels (clip bound)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
s_ready  output  1  block can accept a request
s_valid  input  1  request valid
in_x  input  X_W  rectangle left column
in_y  input  Y_W  rectangle top row
in_w  input  X_W  rectangle width in pixels
in_h  input  Y_W  rectangle height in pixels
in_color  input  COLOR_W  rectangle colour
in_outline  input  1  1 = draw 1-pixel border only, 0 = solid fill
vga_x  output  X_W  pixel column
vga_y  output  Y_W  pixel row
colour  output  COLOR_W  pixel colour
plot  output  1  pixel valid to adapter
vga_ready  input  1  adapter accepts the pixel this cycle
done  output  1  one-cycle pulse when a rectangle completes

Behaviour:
- Reset: reset_n sampled on the clock edge; state=IDLE; iterators col/row=0; latched x, y, w, h, colour and mode=0.
- Reset outputs: plot=0, done=0, vga_x=0, vga_y=0, colour=0, s_ready=1 (combinational from IDLE).
- Reset during DRAW or DONE: drawing is abandoned, no further plot, and the block is back in IDLE next cycle.
- States:
  - IDLE: s_ready=1. On s_valid, latch all in_* fields, clear col/row, and go to DRAW. If in_w==0 or in_h==0, go to DONE instead; no pixels are emitted.
  - DRAW: s_ready=0. The current pixel is (x+col, y+row), raster order: col increments first, then wraps to 0 and row increments.
  - DONE: s_ready=0, done=1 for exactly one cycle, then IDLE.
- Pixel emission condition: a pixel is emitted when it is visible (see clipping) and either fill mode is selected, or outline mode is selected and (col==0 | col==w-1 | row==0 | row==h-1).
- Emitted pixel: plot=1 and the pixel is held stable until vga_ready=1; the iterator advances only on plot&vga_ready.
- Non-emitted pixel: plot=0 and the iterator advances unconditionally, one position per cycle.
- DRAW exit: after the position col==w-1, row==h-1 advances, go to DONE.
- Latency: the request is accepted on cycle N. The first position is presented on cycle N+1. With vga_ready held high and all pixels emitted, plot is high for w*h consecutive cycles, done pulses on the next cycle, and s_ready rises one cycle after that.
- Arithmetic: vga_x = x+col and vga_y = y+row, truncated to X_W / Y_W. Visibility is computed at X_W+1 / Y_W+1 bits: visible iff (x+col)<SCREEN_W and (y+row)<SCREEN_H.
- Outputs outside DRAW: vga_x, vga_y and colour reflect the latched/iterator values; plot=0.
- Inputs are ignored while s_ready=0.

Optional Feature:
- Macro: RECT_DRAWER_CLIP_EN.
- Defined: off-screen positions are not plotted and advance at one per cycle regardless of vga_ready.
- Undefined: every position passing the mode test is plotted, with coordinates simply truncated (wrap-around on screen); SCREEN_W/SCREEN_H are unused.

Test Plan:
- Fill 3x2 at (10,20), colour 5, vga_ready=1 -> plot high 6 consecutive cycles: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done pulses next cycle; s_ready high the cycle after.
- Outline 4x3 at (0,0), vga_ready=1 -> 12 cycles in DRAW; plot low only at (1,1),(2,1); 10 pixels plotted.
- Fill 2x1 with vga_ready low 3 cycles on the first pixel -> (x,y) held with plot=1 for 4 cycles, then the second pixel; total plotted pixels = 2.
- With RECT_DRAWER_CLIP_EN: fill 4x1 at (158,119), screen 160x120 -> pixels (158,119),(159,119) plotted; cols 160,161 skipped with plot=0; then done.
- Zero size: w=0, h=5 -> no plot; done pulses the cycle after acceptance; then IDLE.
- reset_n low mid-way through a 10x10 fill -> next cycle plot=0, done=0, s_ready=1; a new 1x1 request then plots exactly one pixel.
